// File: rtl/haraka_s_absorb_pad.sv
// Byte-serial message packer for Haraka-S: fills RATE_BYTES-wide rate blocks and pads the final block.
// A block is presented the edge after it fills or after end-of-message; in_ready stalls the byte source while a block is held.
// Optional sticky err for data driven during HOLD: define HARAKA_PAD_ERR_EN.
module haraka_s_absorb_pad #(
    parameter int         RATE_BYTES = 32,
    parameter logic [7:0] PAD_BYTE   = 8'h1F
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7:0]              serial_in,
    input  logic                    process_input,
    output logic                    in_ready,
    output logic [8*RATE_BYTES-1:0] block_out,
    output logic                    block_valid,
    output logic                    block_last,
    input  logic                    block_ready,
    output logic                    err
);

    localparam int BW = 8 * RATE_BYTES;
    localparam int CW = (RATE_BYTES > 1) ? $clog2(RATE_BYTES) : 1;

    typedef enum logic [0:0] {
        ABSORB = 1'b0,
        HOLD   = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [BW-1:0]   buf_q;
    logic [BW-1:0]   pad_blk_d;
    logic            valid_q;
    logic            last_q;
    logic            active_q;
    logic            last_byte;

    assign last_byte = (cnt_q == CW'(RATE_BYTES - 1));

    // Pad byte at the first free slot, zeros after it, top bit of the last byte set.
    always_comb begin
        pad_blk_d = buf_q;
        for (int i = 0; i < RATE_BYTES; i++) begin
            if (i == int'(cnt_q))
                pad_blk_d[8*i +: 8] = buf_q[8*i +: 8] | PAD_BYTE;
            else if (i > int'(cnt_q))
                pad_blk_d[8*i +: 8] = 8'h00;
        end
        pad_blk_d[BW-1 -: 8] = pad_blk_d[BW-1 -: 8] | 8'h80;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ABSORB;
            cnt_q    <= '0;
            buf_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                ABSORB: begin
                    // Any sampled process_input pulse, even with enable low, opens a message.
                    if (process_input)
                        active_q <= 1'b1;
                    if (enable && process_input) begin
                        buf_q[8*int'(cnt_q) +: 8] <= serial_in;
                        if (last_byte) begin
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            last_q  <= 1'b0;
                            state_q <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (enable && active_q) begin
                        buf_q   <= pad_blk_d;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (block_ready) begin
                        buf_q   <= '0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= ABSORB;
                        if (last_q)
                            active_q <= 1'b0;
                    end
                end
                default: state_q <= ABSORB;
            endcase
        end
    end

    assign in_ready    = (state_q == ABSORB);
    assign block_out   = buf_q;
    assign block_valid = valid_q;
    assign block_last  = last_q;

`ifdef HARAKA_PAD_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (enable && process_input && !in_ready)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
